// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Contents:
//   OVERSAMPLE   - samples taken per bit time
//   uart_state_t - receiver FSM states
//   uart_div     - clock divider for the oversample tick, rounded to nearest
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_state_t;

    // Rounded clk_freq / (baud * OVERSAMPLE).
    function automatic int unsigned uart_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return (clk_freq + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
// Ports:
//   clk, resetn - clock, asynchronous active-low reset
//   push, din   - write request and data; dropped when full unless popping the same cycle
//   pop         - read request; ignored when empty
//   dout        - head entry, valid while empty=0
//   empty, full - occupancy flags
//   count       - number of entries held
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               dout,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a show-ahead FIFO.
// Ports:
//   clk, resetn      - system clock, asynchronous active-low reset
//   uart_rxp         - serial input, idle high, asynchronous to clk
//   rd_en            - pop FIFO head (ignored when empty)
//   dout             - FIFO head byte, valid while empty=0
//   empty, full      - FIFO occupancy flags
//   count            - FIFO entries held
//   frame_err        - sticky: stop bit sampled low
//   overrun          - sticky: good byte dropped on a full FIFO
//   err_clr          - clears both sticky flags (a same-cycle new error wins)
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 78_750_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               uart_rxp,
    input  logic                               rd_en,
    output logic [7:0]                         dout,
    output logic                               empty,
    output logic                               full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
    output logic                               frame_err,
    output logic                               overrun,
    input  logic                               err_clr
);

    localparam int unsigned DIV = uart_div(CLK_FREQ, BAUD);
    localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic          sync1_q;
    logic          rxs_q;
    logic [TW-1:0] tick_cnt_q;
    logic          tick;
    logic [3:0]    sc_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    uart_state_t   state_q;
    logic          frame_err_q;
    logic          overrun_q;
    logic          stop_sample;
    logic          byte_good;
    logic          frame_bad;
    logic          overrun_set;

    // Two-stage synchronizer; resets to the idle line level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= uart_rxp;
            rxs_q   <= sync1_q;
        end
    end

    assign tick = (tick_cnt_q == TW'(DIV - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            sc_q       <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
            if (tick) begin
                sc_q <= sc_q + 4'd1;
            end
            case (state_q)
                IDLE: begin
                    // Restart the bit timing from the falling edge.
                    if (!rxs_q) begin
                        tick_cnt_q <= '0;
                        sc_q       <= '0;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (tick && sc_q == 4'd7) begin
                        if (rxs_q) begin
                            state_q <= IDLE;
                        end else begin
                            sc_q    <= '0;
                            bit_q   <= '0;
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (tick && sc_q == 4'd15) begin
                        shift_q <= {rxs_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick && sc_q == 4'd15) begin
                        state_q <= rxs_q ? IDLE : BREAK;
                    end
                end
                BREAK: begin
                    // Absorb a held-low line so it reports only one frame error.
                    if (rxs_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stop_sample = (state_q == STOP) && tick && (sc_q == 4'd15);
    assign byte_good   = stop_sample && rxs_q;
    assign frame_bad   = stop_sample && !rxs_q;
    assign overrun_set = byte_good && full && !rd_en;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_bad   || (frame_err_q && !err_clr);
            overrun_q   <= overrun_set || (overrun_q && !err_clr);
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (byte_good),
        .pop    (rd_en),
        .din    (shift_q),
        .dout   (dout),
        .empty  (empty),
        .full   (full),
        .count  (count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at DIV=4 (64 clocks per bit).
module tb_uart_rx_fifo;

    localparam int unsigned CLK_FREQ   = 7_372_800;
    localparam int unsigned BAUD       = 115200;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned BIT_CLKS   = 64;
    // Posedge (counted from the start-bit drive) on which the stop bit is sampled:
    // 2 synchronizer edges + 1 IDLE edge + 152 ticks of 4 clocks.
    localparam int unsigned PUSH_EDGE  = 611;

    logic       clk = 1'b0;
    logic       resetn;
    logic       uart_rxp;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;
    int waits;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .uart_rxp  (uart_rxp),
        .rd_en     (rd_en),
        .dout      (dout),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // All stimulus tasks start and end on a negedge.
    task automatic drive_bits(input logic [7:0] b);
        uart_rxp = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxp = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bits(b);
        uart_rxp = stop_bit;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Send a good frame and strobe rd_en or err_clr exactly on its push edge.
    task automatic send_strobed(input logic [7:0] b, input bit use_rd);
        fork
            send_frame(b, 1'b1);
            begin
                repeat (PUSH_EDGE - 1) @(posedge clk);
                @(negedge clk);
                if (use_rd) rd_en = 1'b1;
                else err_clr = 1'b1;
                @(negedge clk);
                rd_en   = 1'b0;
                err_clr = 1'b0;
            end
        join
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check({tag, "_nonempty"}, 32'(empty), 32'd0);
        check(tag, 32'(dout), 32'(exp));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        resetn   = 1'b0;
        uart_rxp = 1'b1;
        rd_en    = 1'b0;
        err_clr  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout", 32'(dout), 32'h00);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        resetn = 1'b1;
        repeat (10) @(negedge clk);

        // 1: single byte, latency measured from the stop-bit midpoint on the pin.
        drive_bits(8'hA5);
        uart_rxp = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clk);
        waits = 0;
        while (empty && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        // 2 synchronizer cycles plus up to 2 cycles from the synchronized midpoint.
        check("t1_latency_le4", 32'(waits <= 4), 32'd1);
        repeat (40) @(negedge clk);
        check("t1_count", 32'(count), 32'd1);
        pop_expect("t1_dout", 8'hA5);
        check("t1_empty_after_pop", 32'(empty), 32'd1);
        check("t1_count_after_pop", 32'(count), 32'd0);

        // 2: back-to-back bytes.
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        send_frame(8'h3C, 1'b1);
        repeat (20) @(negedge clk);
        check("t2_count_peak", 32'(count), 32'd4);
        check("t2_frame_err", 32'(frame_err), 32'd0);
        check("t2_overrun", 32'(overrun), 32'd0);
        pop_expect("t2_b0", 8'h00);
        pop_expect("t2_b1", 8'hFF);
        pop_expect("t2_b2", 8'h55);
        pop_expect("t2_b3", 8'h3C);
        check("t2_empty", 32'(empty), 32'd1);

        // 3: 20-clock glitch is a false start.
        uart_rxp = 1'b0;
        repeat (20) @(negedge clk);
        uart_rxp = 1'b1;
        repeat (200) @(negedge clk);
        check("t3_count", 32'(count), 32'd0);
        check("t3_frame_err", 32'(frame_err), 32'd0);
        check("t3_overrun", 32'(overrun), 32'd0);
        send_frame(8'h81, 1'b1);
        repeat (20) @(negedge clk);
        pop_expect("t3_dout", 8'h81);

        // 4: framing error then break; clearing mid-break proves no second error.
        send_frame(8'h12, 1'b0);
        check("t4_frame_err", 32'(frame_err), 32'd1);
        check("t4_count", 32'(count), 32'd0);
        pulse_clr();
        repeat (30 * BIT_CLKS) @(negedge clk);
        uart_rxp = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("t4_single_err", 32'(frame_err), 32'd0);
        check("t4_count_break", 32'(count), 32'd0);
        send_frame(8'h34, 1'b1);
        repeat (20) @(negedge clk);
        pop_expect("t4_dout", 8'h34);
        check("t4_frame_err_clear", 32'(frame_err), 32'd0);

        // 5: overrun; err_clr on the overrun edge must lose to the new event.
        for (int i = 1; i <= 8; i++) begin
            send_frame(8'(i), 1'b1);
        end
        send_strobed(8'h09, 1'b0);
        repeat (20) @(negedge clk);
        check("t5_full", 32'(full), 32'd1);
        check("t5_count", 32'(count), 32'd8);
        check("t5_overrun_set_wins", 32'(overrun), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            pop_expect($sformatf("t5_b%0d", i), 8'(i));
        end
        check("t5_empty", 32'(empty), 32'd1);
        pulse_clr();
        check("t5_overrun_clr", 32'(overrun), 32'd0);

        // 6a: pop on the same edge a 9th byte arrives.
        for (int i = 0; i < 8; i++) begin
            send_frame(8'h11 + 8'(i), 1'b1);
        end
        check("t6a_full_before", 32'(full), 32'd1);
        send_strobed(8'h19, 1'b1);
        repeat (20) @(negedge clk);
        check("t6a_overrun", 32'(overrun), 32'd0);
        check("t6a_count", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            pop_expect($sformatf("t6a_b%0d", i), 8'h12 + 8'(i));
        end
        check("t6a_empty", 32'(empty), 32'd1);

        // 6b: asynchronous reset mid-DATA with state to clear.
        send_frame(8'h00, 1'b0);
        uart_rxp = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        send_frame(8'h5A, 1'b1);
        check("t6b_pre_count", 32'(count), 32'd1);
        check("t6b_pre_frame_err", 32'(frame_err), 32'd1);
        uart_rxp = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        uart_rxp = 1'b1;
        repeat (2 * BIT_CLKS + 30) @(negedge clk);
        #3 resetn = 1'b0;
        #1;
        check("t6b_dout", 32'(dout), 32'h00);
        check("t6b_empty", 32'(empty), 32'd1);
        check("t6b_full", 32'(full), 32'd0);
        check("t6b_count", 32'(count), 32'd0);
        check("t6b_frame_err", 32'(frame_err), 32'd0);
        check("t6b_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        uart_rxp = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (10 * BIT_CLKS) @(negedge clk);
        check("t6b_no_stray", 32'(count), 32'd0);
        send_frame(8'h66, 1'b1);
        repeat (20) @(negedge clk);
        pop_expect("t6b_recover", 8'h66);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
